// File: rtl/mm_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/DIV register window feeding a
// small TX FIFO that drains into a start/data/stop serializer.
module mm_uart_tx #(
  parameter logic [15:0] BASE_ADDR = 16'hC000,
  parameter int unsigned DEPTH     = 4,
  parameter logic [15:0] DEF_DIV   = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        mm_we,
  input  logic        mm_re,
  output logic [15:0] rdata,
  output logic        tx
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [15:0]   r_div;
  logic [15:0]   r_div_lat;
  logic [15:0]   r_baud;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit;
  logic          r_tx;
  state_t        r_state;
  state_t        w_next;

  logic        w_sel_tx;
  logic        w_sel_st;
  logic        w_sel_div;
  logic        w_full;
  logic        w_empty;
  logic        w_push_req;
  logic        w_push;
  logic        w_ovf_set;
  logic        w_pop;
  logic        w_busy;
  logic        w_tx_next;
  logic        w_baud_zero;
  logic [15:0] w_status;

  assign w_sel_tx    = (addr == BASE_ADDR);
  assign w_sel_st    = (addr == BASE_ADDR + 16'd1);
  assign w_sel_div   = (addr == BASE_ADDR + 16'd2);
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push_req  = mm_we && w_sel_tx;
  // Full is judged on the registered count, so a same-cycle pop never rescues a push.
  assign w_push      = w_push_req && !w_full;
  assign w_ovf_set   = w_push_req && w_full;
  assign w_baud_zero = (r_baud == '0);

  // FIFO storage: contents need no reset, pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_div <= DEF_DIV;
    end else begin
      if (w_ovf_set)                r_ovf <= 1'b1;
      else if (mm_re && w_sel_st)   r_ovf <= 1'b0;
      if (mm_we && w_sel_div)       r_div <= wdata;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty)                      w_next = S_START;
      S_START: if (w_baud_zero)                   w_next = S_DATA;
      S_DATA:  if (w_baud_zero && r_bit == 3'd7)  w_next = S_STOP;
      S_STOP:  if (w_baud_zero)                   w_next = S_IDLE;
      default:                                    w_next = S_IDLE;
    endcase
  end

  // FSM outputs; r_shift[0] always holds the data bit currently on the line.
  always_comb begin
    w_pop     = (r_state == S_IDLE) && !w_empty;
    w_busy    = (r_state != S_IDLE);
    w_tx_next = 1'b1;
    case (w_next)
      S_START: w_tx_next = 1'b0;
      S_DATA: begin
        if (r_state == S_DATA && w_baud_zero) w_tx_next = r_shift[1];
        else                                  w_tx_next = r_shift[0];
      end
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx      <= 1'b1;
      r_baud    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_div_lat <= DEF_DIV;
    end else begin
      r_tx <= w_tx_next;
      if (w_pop) begin
        r_shift   <= r_mem[r_rptr];
        r_div_lat <= r_div;
        r_baud    <= r_div;
        r_bit     <= '0;
      end else if (r_state != S_IDLE) begin
        if (w_baud_zero) begin
          r_baud <= r_div_lat;
          if (r_state == S_DATA) begin
            r_bit   <= r_bit + 3'd1;
            r_shift <= {1'b0, r_shift[7:1]};
          end
        end else begin
          r_baud <= r_baud - 16'd1;
        end
      end
    end
  end

  assign w_status = {9'd0, r_ovf, 3'(r_count), w_busy, w_empty, w_full};

  always_comb begin
    rdata = '0;
    if (mm_re) begin
      if (w_sel_st)       rdata = w_status;
      else if (w_sel_div) rdata = r_div;
    end
  end

  assign tx = r_tx;

endmodule

// File: tb/tb_mm_uart_tx.sv
// Bench for mm_uart_tx: register vector table, directed frame sequences, and random
// bursts checked by a frame-level scoreboard on the tx line.
module tb_mm_uart_tx;

  localparam logic [15:0] BASE = 16'hC000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        mm_we;
  logic        mm_re;
  logic [15:0] rdata;
  logic        tx;

  mm_uart_tx #(.BASE_ADDR(BASE), .DEPTH(4), .DEF_DIV(16'd433)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
    .mm_we(mm_we), .mm_re(mm_re), .rdata(rdata), .tx(tx)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] m_div;
  bit          mon_en;

  typedef struct {
    logic        we;
    logic        re;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    mm_we = 1'b0;
    mm_re = 1'b0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic store(input logic [7:0] b, input bit accept);
    mm_we = 1'b1;
    mm_re = 1'b0;
    addr  = BASE;
    wdata = {8'h00, b};
    if (accept) exp_q.push_back(b);
    tick();
  endtask

  task automatic write_div(input logic [15:0] v);
    mm_we = 1'b1;
    mm_re = 1'b0;
    addr  = BASE + 16'd2;
    wdata = v;
    m_div = v;
    tick();
    idle_bus();
  endtask

  task automatic read_chk(input string name, input logic [15:0] a, input logic [15:0] exp);
    mm_we = 1'b0;
    mm_re = 1'b1;
    addr  = a;
    @(negedge clk);
    chk(name, rdata, exp);
    tick();
    idle_bus();
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done = 1'b0;
    mm_we = 1'b0;
    mm_re = 1'b1;
    addr  = BASE + 16'd1;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (rdata == 16'h0002) done = 1'b1;
      tick();
    end
    idle_bus();
    chk({name, "_idle"}, 32'(done), 32'd1);
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Polls full before storing, so every store issued here must be accepted.
  task automatic store_safe(input logic [7:0] b);
    bit ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      mm_we = 1'b0;
      mm_re = 1'b1;
      addr  = BASE + 16'd1;
      @(negedge clk);
      if (rdata[0] == 1'b0) ok = 1'b1;
      tick();
    end
    if (ok) store(b, 1'b1);
    idle_bus();
    chk("store_room", 32'(ok), 32'd1);
  endtask

  // Scoreboard: every falling edge from idle is a frame of 10 bits, each DIV+1 clocks.
  initial begin
    logic       prev;
    logic [7:0] eb;
    logic [9:0] expf;
    logic [9:0] got;
    bit         bad;
    int         d;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev === 1'b1 && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
        end else begin
          eb   = exp_q.pop_front();
          d    = int'(m_div);
          expf = {1'b1, eb, 1'b0};
          got  = '0;
          bad  = 1'b0;
          for (int b = 0; b < 10; b++) begin
            for (int c = 0; c <= d; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (tx !== expf[b]) bad = 1'b1;
              if (c == 0) got[b] = tx;
            end
          end
          chk($sformatf("frame_%02h_div%0d", eb, d), {21'd0, bad, got}, {22'd0, expf});
        end
      end
      prev = tx;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b2;
    logic       expbit;

    tbl[0]  = '{1'b0, 1'b1, BASE + 16'd1, 16'h0000, 16'h0002};
    tbl[1]  = '{1'b0, 1'b1, BASE + 16'd2, 16'h0000, 16'd433};
    tbl[2]  = '{1'b0, 1'b1, BASE,         16'h0000, 16'h0000};
    tbl[3]  = '{1'b0, 1'b1, BASE + 16'd3, 16'h0000, 16'h0000};
    tbl[4]  = '{1'b0, 1'b0, BASE + 16'd2, 16'h0000, 16'h0000};
    tbl[5]  = '{1'b1, 1'b0, BASE + 16'd2, 16'h1234, 16'h0000};
    tbl[6]  = '{1'b0, 1'b1, BASE + 16'd2, 16'h0000, 16'h1234};
    tbl[7]  = '{1'b1, 1'b0, BASE + 16'd3, 16'hFFFF, 16'h0000};
    tbl[8]  = '{1'b0, 1'b1, BASE + 16'd3, 16'h0000, 16'h0000};
    tbl[9]  = '{1'b0, 1'b1, BASE + 16'd1, 16'h0000, 16'h0002};
    tbl[10] = '{1'b1, 1'b1, 16'h0002,     16'h0055, 16'h0000};
    tbl[11] = '{1'b1, 1'b1, BASE + 16'd2, 16'h0005, 16'h1234};
    tbl[12] = '{1'b0, 1'b1, BASE + 16'd2, 16'h0000, 16'h0005};

    rst    = 1'b1;
    mon_en = 1'b1;
    m_div  = 16'd433;
    idle_bus();
    repeat (3) tick();
    rst = 1'b0;

    // Register map, reset values, out-of-window accesses
    for (int i = 0; i < 13; i++) begin
      mm_we = tbl[i].we;
      mm_re = tbl[i].re;
      addr  = tbl[i].a;
      wdata = tbl[i].d;
      if (tbl[i].we && tbl[i].a == BASE + 16'd2) m_div = tbl[i].d;
      @(negedge clk);
      chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_tx", i), tx, 1'b1);
      tick();
    end
    idle_bus();

    // Single 0xA5 frame at DIV=3, waveform checked cycle by cycle
    write_div(16'd3);
    store(8'hA5, 1'b1);
    mm_we = 1'b0;
    mm_re = 1'b1;
    addr  = BASE + 16'd1;
    @(negedge clk);
    chk("t2_queued_status", rdata, 16'h0008);
    chk("t2_pre_tx", tx, 1'b1);
    tick();
    b2 = 8'hA5;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i < 4)        expbit = 1'b0;
      else if (i >= 36) expbit = 1'b1;
      else              expbit = b2[i / 4 - 1];
      chk($sformatf("t2_tx_c%0d", i), tx, expbit);
      if (i == 0 || i == 39) chk($sformatf("t2_busy_c%0d", i), rdata, 16'h0006);
      tick();
    end
    @(negedge clk);
    chk("t2_done_status", rdata, 16'h0002);
    chk("t2_done_tx", tx, 1'b1);
    tick();
    idle_bus();

    // Fill to full at DIV=0, overflow is sticky until one STATUS read
    write_div(16'd0);
    for (int k = 1; k <= 5; k++) store(8'(k), 1'b1);
    store(8'h06, 1'b0);
    mm_we = 1'b0;
    mm_re = 1'b1;
    addr  = BASE + 16'd1;
    @(negedge clk);
    chk("t3_ovf_status", rdata, 16'h0065);
    tick();
    @(negedge clk);
    chk("t3_ovf_cleared", rdata, 16'h0025);
    tick();
    idle_bus();
    wait_idle("t3", 500);

    // DIV change mid-frame affects only the following frame
    write_div(16'd3);
    store(8'h3C, 1'b1);
    store(8'hC3, 1'b1);
    idle_bus();
    repeat (10) tick();
    write_div(16'd7);
    read_chk("t4_div_readback", BASE + 16'd2, 16'd7);
    wait_idle("t4", 500);

    // Reset during data bit 3 aborts the frame and discards the queue
    mon_en = 1'b0;
    write_div(16'd3);
    store(8'h00, 1'b0);
    store(8'h55, 1'b0);
    idle_bus();
    repeat (17) tick();
    @(negedge clk);
    chk("t5_bit3_low", tx, 1'b0);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("t5_tx_after_rst", tx, 1'b1);
    rst   = 1'b0;
    m_div = 16'd433;
    read_chk("t5_status", BASE + 16'd1, 16'h0002);
    read_chk("t5_div", BASE + 16'd2, 16'd433);
    exp_q.delete();
    mon_en = 1'b1;

    // Random bursts of bytes at random small divisors
    for (int burst = 0; burst < 4; burst++) begin
      write_div(16'($urandom_range(0, 5)));
      for (int k = 0; k < int'($urandom_range(4, 9)); k++) begin
        repeat ($urandom_range(0, 12)) tick();
        store_safe(8'($urandom));
      end
      wait_idle($sformatf("rnd%0d", burst), 2000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
